// File: rtl/wb_arb_pkg.sv
// Shared types, constants and helpers for the Wishbone round-robin arbiter.
// Defining WB_ARB_TIMEOUT_EN adds the TERM state used by the stall watchdog.
package wb_arb_pkg;

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_TERM  = 2'd2
    } arb_state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;
`endif

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin priority search: first requester after the last owner wins.
// Purely combinational; the caller registers the one-hot result.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int LW          = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [LW-1:0]          i_last,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic                   o_valid
);

    int   w_pos;
    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_pos   = int'(i_last);
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_pos = rr_next(w_pos, NUM_MASTERS);
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!w_found && (j == w_pos) && i_req[j]) begin
                    o_grant[j] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone B3 slave among NUM_MASTERS masters.
// Define WB_ARB_TIMEOUT_EN to enable the stalled-slave watchdog (TERM state).
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rstn_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_MASTERS-1:0]      m_rty_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = DW / 8;

    arb_state_e             r_state;
    arb_state_e             w_next;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_pick;
    logic                   w_pick_valid;
    logic [LW-1:0]          r_last;
    logic [LW-1:0]          w_owner;
    logic                   w_own_cyc;
    logic                   w_own_stb;
    logic                   w_own_we;
    logic                   w_hit;
    logic                   w_live;
    logic [AW-1:0]          w_adr;
    logic [DW-1:0]          w_dat;
    logic [SW-1:0]          w_sel;
    logic [2:0]             w_cti;
    logic [1:0]             w_bte;

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .LW          (LW)
    ) u_pick (
        .i_req   (m_cyc_i),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    // One-hot AND-OR mux; everything reads zero when nobody owns the bus.
    always_comb begin
        w_adr   = '0;
        w_dat   = '0;
        w_sel   = '0;
        w_cti   = '0;
        w_bte   = '0;
        w_owner = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (r_grant[j]) begin
                w_adr   = w_adr | m_adr_i[j*AW +: AW];
                w_dat   = w_dat | m_dat_i[j*DW +: DW];
                w_sel   = w_sel | m_sel_i[j*SW +: SW];
                w_cti   = w_cti | m_cti_i[j*3 +: 3];
                w_bte   = w_bte | m_bte_i[j*2 +: 2];
                w_owner = LW'(j);
            end
        end
    end

    assign w_own_cyc = |(r_grant & m_cyc_i);
    assign w_own_stb = |(r_grant & m_stb_i);
    assign w_own_we  = |(r_grant & m_we_i);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          w_term;

    assign w_term = s_ack_i | s_err_i | s_rty_i;
    assign w_hit  = (r_state == ST_OWNED) &&
                    (r_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            r_cnt <= '0;
        end else if (r_state != ST_OWNED || w_next != ST_OWNED || w_term) begin
            r_cnt <= '0;
        end else if (s_stb_o) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= LW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE) begin
                r_grant <= w_pick;
            end else if (w_next == ST_IDLE) begin
                r_grant <= '0;
                r_last  <= w_owner;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) w_next = ST_OWNED;
            end
            ST_OWNED: begin
                if (!w_own_cyc) begin
                    w_next = ST_IDLE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (w_hit) begin
                    w_next = ST_TERM;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_TERM: begin
                if (!w_own_cyc) w_next = ST_IDLE;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    // A watchdog hit cuts the slave off and answers the owner with err.
    always_comb begin
        w_live  = (r_state == ST_OWNED) && !w_hit;
        s_cyc_o = w_live & w_own_cyc;
        s_stb_o = w_live & w_own_stb;
        s_we_o  = w_live & w_own_we;
        s_adr_o = w_adr;
        s_dat_o = w_dat;
        s_sel_o = w_sel;
        s_cti_o = w_cti;
        s_bte_o = w_bte;
        m_ack_o = w_live ? (r_grant & {NUM_MASTERS{s_ack_i}}) : '0;
        m_rty_o = w_live ? (r_grant & {NUM_MASTERS{s_rty_i}}) : '0;
        m_err_o = w_live ? (r_grant & {NUM_MASTERS{s_err_i}}) :
                  (w_hit ? r_grant : '0);
    end

    assign grant_o = r_grant;
    assign m_dat_o = s_dat_i;

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3, number of Wishbone B3 masters sharing one slave port.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width; select width is DW/8.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, stall limit in cycles for the watchdog (REQ-019).
REQ-005 Clocking and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-006 Ports SHALL be:
- wb_clk_i  in  1  clock.
- wb_rstn_i  in  1  synchronous active-low reset.
- m_adr_i  in  NUM_MASTERS*AW  master addresses, packed, master 0 in the LSBs.
- m_dat_i  in  NUM_MASTERS*DW  master write data.
- m_sel_i  in  NUM_MASTERS*DW/8  master byte selects.
- m_cti_i  in  NUM_MASTERS*3  master cycle type.
- m_bte_i  in  NUM_MASTERS*2  master burst type.
- m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS each  per-master strobes.
- m_dat_o  out  DW  read data, broadcast to all masters.
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  per-master terminations.
- s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_we_o, s_cyc_o, s_stb_o  out  slave-side copies of the master signals.
- s_dat_i, s_ack_i, s_err_i, s_rty_i  in  slave responses.
- grant_o  out  NUM_MASTERS  one-hot current owner, all zeros when idle.

Function
REQ-007 The FSM SHALL have states IDLE and OWNED, plus TERM when the watchdog is compiled in.
REQ-008 In IDLE with any m_cyc_i set, the arbiter SHALL register a grant to the first requester found searching round-robin from (last_owner+1) mod NUM_MASTERS, and SHALL move to OWNED on the next cycle.
REQ-009 Arbitration latency SHALL be exactly 1 cycle from m_cyc_i rising to s_cyc_o rising.
REQ-010 In OWNED, all s_* outputs SHALL combinationally mirror the granted master's signals.
REQ-011 In IDLE, s_cyc_o and s_stb_o SHALL be 0.
REQ-012 s_ack_i, s_err_i and s_rty_i SHALL be routed only to the granted master; all other masters' termination bits SHALL be 0.
REQ-013 m_dat_o SHALL equal s_dat_i at all times.
REQ-014 Ownership SHALL persist while the granted master's m_cyc_i stays high, including across CTI 3'b001/3'b010 bursts and stb-low gaps; other requesters SHALL NOT be served during this time.
REQ-015 When the granted m_cyc_i falls, the arbiter SHALL return to IDLE, update last_owner, and clear grant_o in the same edge; exactly one dead cycle SHALL separate consecutive owners.
REQ-016 Simultaneous requests SHALL be served in round-robin order with no starvation: each requester is served within NUM_MASTERS grants.
REQ-017 A requester whose m_cyc_i drops before being granted SHALL be skipped without side effects.

Reset
REQ-018 With wb_rstn_i low at a clock edge: state = IDLE, grant_o = 0, last_owner = NUM_MASTERS-1 (so master 0 wins first), watchdog counter = 0, all outputs 0; a reset mid-transfer SHALL drop s_cyc_o on the next cycle.

Configuration
REQ-019 With WB_ARB_TIMEOUT_EN defined: in OWNED, a counter SHALL increment each cycle with s_stb_o=1 and no slave termination, and SHALL clear on any termination or new grant. On reaching TIMEOUT_CYCLES, the block SHALL pulse m_err_o for the owner for 1 cycle, force s_cyc_o/s_stb_o to 0, and enter TERM. TERM SHALL return to IDLE when the owner drops m_cyc_i.
REQ-020 Without WB_ARB_TIMEOUT_EN: no counter and no TERM state; a stalled slave SHALL hold the bus indefinitely.

Structure
REQ-021 A shared package wb_arb_pkg SHALL hold the state enum, the CTI/BTE constants (CTI_CLASSIC, CTI_INCR, CTI_EOB) and a round-robin next-index function.
REQ-022 The round-robin priority search SHALL be one sub-module, wb_rr_pick (request vector, last owner -> one-hot grant, valid).

Verification
REQ-023 Reset then m_cyc_i=3'b111 -> grant_o sequence 001, 010, 100, 001 across four single transfers, with one dead cycle between each.
REQ-024 Master 1 runs an 8-beat INCR burst (CTI 010...111) while master 0 requests -> grant_o stays 010 for all 8 acks; master 0 is granted 2 cycles after master 1 drops cyc.
REQ-025 Master 2 reads adr 32'hF000_0100, slave returns 32'hDEAD_BEEF with ack -> m_ack_o=3'b100 and m_dat_o=32'hDEAD_BEEF in the same cycle; m_ack_o[1:0]=0.
REQ-026 Slave asserts s_err_i for master 0 -> m_err_o=3'b001 for 1 cycle, and ownership is held until master 0 drops cyc.
REQ-027 With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks -> m_err_o pulses after 16 stalled cycles, s_cyc_o falls, and the next requester is granted after the owner releases; without the macro, s_cyc_o stays high for 1000 cycles.
REQ-028 Assert wb_rstn_i=0 mid-burst -> s_cyc_o=0 and grant_o=0 on the next edge; after release, master 0 is granted first.
